dmem_responder: RTL and testbench

//  Bus-target data memory answering the processor's load/store requests over a valid/ready request and response channel.

---
 rtl/dmem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Bus-target data memory that answers load/store requests from the processor's
// data-memory port over a valid/ready request channel and a valid/ready
// response channel. It behaves like a slow RAM: every accepted request waits
// LATENCY cycles before its response appears. This lets the core's stall
// logic be exercised.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words stored (power of two)
//   LATENCY      wait cycles between request acceptance and response (0..15)
//   BASE_ADDR    byte address of word 0
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (high only while idle)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   rsp_valid  response present
//   rsp_ready  requester takes the response
//   rsp_rdata  load data (0 for stores and faulted accesses)
//   rsp_err    access fault
//
// Build option
//   DMEM_ERR_EN  When defined, an access faults if it is misaligned, below
//                BASE_ADDR, or past the last word. A faulted access returns
//                rsp_err=1 and rsp_rdata=0, and it never writes memory.
//                When undefined, rsp_err stays 0, the low address bits are
//                ignored, and the word index wraps modulo DEPTH_WORDS.

module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  stateT             state;
  logic [CNT_W-1:0]  cnt;

  logic              pendWe;
  logic [IDX_W-1:0]  pendIdx;
  logic [31:0]       pendWdata;
  logic              pendFault;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic [31:0]       reqOffset;
  logic [IDX_W-1:0]  reqIdx;
  logic              reqFault;
  logic              unusedOffset;

  logic              selWe;
  logic [IDX_W-1:0]  selIdx;
  logic [31:0]       selWdata;
  logic              selFault;
  logic              toResp;
  logic              memWe;
  logic [31:0]       respData;

  // req_ready is only high in IDLE, so it alone qualifies the accept edge.
  assign accept    = req_valid & req_ready;
  assign reqOffset = req_addr - BASE_ADDR;
  assign reqIdx    = reqOffset[IDX_W+1:2];

  // Not every offset bit feeds the index. The XOR keeps the whole word
  // visibly consumed in both builds.
  assign unusedOffset = ^reqOffset;

`ifdef DMEM_ERR_EN
  // Misaligned, below the base address, or beyond the last stored word.
  assign reqFault = (req_addr[1:0] != 2'b00) ||
                    (req_addr < BASE_ADDR) ||
                    ((reqOffset >> 2) >= 32'(DEPTH_WORDS));
`else
  assign reqFault = 1'b0;
`endif

  // The transaction that enters RESP on this edge comes from one of two places.
  // With zero latency, it is the request being accepted right now. Otherwise it
  // is the one captured earlier and now finishing its wait.
  always_comb begin
    selWe    = pendWe;
    selIdx   = pendIdx;
    selWdata = pendWdata;
    selFault = pendFault;
    toResp   = 1'b0;
    if (state == IDLE) begin
      selWe    = req_we;
      selIdx   = reqIdx;
      selWdata = req_wdata;
      selFault = reqFault;
      toResp   = accept && (LATENCY == 0);
    end else if (state == WAIT) begin
      toResp = (cnt == '0);
    end
  end

  // The store commits on the edge that enters RESP. Gating with reset means a
  // request that is still pending when reset is asserted never lands in memory.
  assign memWe    = toResp & selWe & ~selFault & ~reset;
  assign respData = (selWe || selFault) ? 32'h0 : mem[selIdx];

  // The storage array has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[selIdx] <= selWdata;
    end
  end

  // Handshake FSM with registered outputs. The response data and error flag
  // are latched once on entry to RESP. They then stay frozen until the
  // requester takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      pendWe    <= 1'b0;
      pendIdx   <= '0;
      pendWdata <= 32'h0;
      pendFault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pendWe    <= req_we;
            pendIdx   <= reqIdx;
            pendWdata <= req_wdata;
            pendFault <= reqFault;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= respData;
              rsp_err   <= selFault;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= respData;
            rsp_err   <= selFault;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances share one clock and one
// reset. Index 0 is built with LATENCY=0 and index 1 with LATENCY=2. Each
// instance has its own request and response signals.

module tb_dmem_responder;

  logic              clk;
  logic              reset;
  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [1:0]        reqWe;
  logic [1:0][31:0]  reqAddr;
  logic [1:0][31:0]  reqWdata;
  logic [1:0]        rspValid;
  logic [1:0]        rspReady;
  logic [1:0][31:0]  rspRdata;
  logic [1:0]        rspErr;

  int total = 0;
  int bad   = 0;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (0),
    .BASE_ADDR  (32'h0000_0000)
  ) dutLat0 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(reqValid[0]),
    .req_ready(reqReady[0]),
    .req_we   (reqWe[0]),
    .req_addr (reqAddr[0]),
    .req_wdata(reqWdata[0]),
    .rsp_valid(rspValid[0]),
    .rsp_ready(rspReady[0]),
    .rsp_rdata(rspRdata[0]),
    .rsp_err  (rspErr[0])
  );

  dmem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (2),
    .BASE_ADDR  (32'h0000_0000)
  ) dutLat2 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(reqValid[1]),
    .req_ready(reqReady[1]),
    .req_we   (reqWe[1]),
    .req_addr (reqAddr[1]),
    .req_wdata(reqWdata[1]),
    .rsp_valid(rspValid[1]),
    .rsp_ready(rspReady[1]),
    .rsp_rdata(rspRdata[1]),
    .rsp_err  (rspErr[1])
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. It counts every check and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One complete transaction on instance d. The task is entered 1 unit after
  // a clock edge while the instance is idle.
  // - The request is offered and accepted on the next edge. Right after that
  //   edge the request fields are scrambled, because they must be ignored.
  // - The response is then awaited for a bounded number of cycles.
  // - It is held for holdCycles with rsp_ready low, then taken.
  task automatic applyStimulus(input int d, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int holdCycles, input int expLat,
                               input logic [31:0] expRdata, input logic expErr);
    int lat;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqValid[d] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[d] = 1'b0;
    reqWe[d]    = ~we;
    reqAddr[d]  = ~addr;
    reqWdata[d] = ~wdata;
    lat = 0;
    while (rspValid[d] !== 1'b1 && lat < 20) begin
      checkOutput("busyReqReady", 32'(reqReady[d]), 32'h0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("respReqReady", 32'(reqReady[d]), 32'h0);
    checkOutput("respRdata", rspRdata[d], expRdata);
    checkOutput("respErr", 32'(rspErr[d]), 32'(expErr));
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdValid", 32'(rspValid[d]), 32'h1);
      checkOutput("holdRdata", rspRdata[d], expRdata);
      checkOutput("holdErr", 32'(rspErr[d]), 32'(expErr));
      checkOutput("holdReqReady", 32'(reqReady[d]), 32'h0);
    end
    rspReady[d] = 1'b1;
    @(posedge clk);
    #1;
    rspReady[d] = 1'b0;
    checkOutput("doneValid", 32'(rspValid[d]), 32'h0);
    checkOutput("doneReqReady", 32'(reqReady[d]), 32'h1);
    checkOutput("doneRdata", rspRdata[d], 32'h0);
    checkOutput("doneErr", 32'(rspErr[d]), 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    rspReady = '0;

    // Reset values on both instances.
    #12;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstReqReady", 32'(reqReady[d]), 32'h1);
      checkOutput("rstRspValid", 32'(rspValid[d]), 32'h0);
      checkOutput("rstRdata", rspRdata[d], 32'h0);
      checkOutput("rstErr", 32'(rspErr[d]), 32'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-WAIT: a store of 0x55 to 0x8 must be dropped. The word keeps
    // the 0x11 written beforehand.
    $display("[TB] reset during wait");
    applyStimulus(1, 1'b1, 32'h8, 32'h11, 0, 2, 32'h0, 1'b0);
    reqWe[1]    = 1'b1;
    reqAddr[1]  = 32'h8;
    reqWdata[1] = 32'h55;
    reqValid[1] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    checkOutput("midRstReqReady", 32'(reqReady[1]), 32'h1);
    checkOutput("midRstRspValid", 32'(rspValid[1]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postRstReqReady", 32'(reqReady[1]), 32'h1);
    checkOutput("postRstRspValid", 32'(rspValid[1]), 32'h0);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 0, 2, 32'h11, 1'b0);

    // Two wait states: store then load at 0x10.
    $display("[TB] latency two");
    applyStimulus(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 2, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 0, 2, 32'hDEAD_BEEF, 1'b0);

    // Zero wait states: the response follows the accept edge directly, and a
    // five-cycle stall keeps it frozen.
    $display("[TB] latency zero with stall");
    applyStimulus(0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, 0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 5, 0, 32'hCAFE_F00D, 1'b0);

    // Back-to-back store then load to the same word on both instances.
    $display("[TB] back to back");
    applyStimulus(1, 1'b1, 32'h4, 32'h1234, 0, 2, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 0, 2, 32'h1234, 1'b0);
    applyStimulus(0, 1'b1, 32'h4, 32'hABCD, 0, 0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h4, 32'h0, 0, 0, 32'hABCD, 1'b0);

    // Address boundaries.
    $display("[TB] address boundaries");
    applyStimulus(1, 1'b1, 32'h0, 32'h77, 0, 2, 32'h0, 1'b0);
`ifdef DMEM_ERR_EN
    applyStimulus(1, 1'b1, 32'h6, 32'h99, 0, 2, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 0, 2, 32'h1234, 1'b0);
    applyStimulus(1, 1'b0, 32'h100, 32'h0, 0, 2, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 0, 2, 32'h77, 1'b0);
`else
    applyStimulus(1, 1'b0, 32'h100, 32'h0, 0, 2, 32'h77, 1'b0);
    applyStimulus(1, 1'b1, 32'h6, 32'h99, 0, 2, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 0, 2, 32'h99, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
